// File: rtl/nes_pkg.sv
// Shared NES definitions: bus addresses of the sprite DMA trigger
// and OAM data port, plus the OAM DMA state encoding.
package nes_pkg;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: stalls the CPU and copies one 256-byte page
// into the PPU OAM data port, one read/write pair per byte.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = nes_pkg::DMA_REG,
    parameter logic [15:0] OAM_PORT = nes_pkg::OAM_PORT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_we,
    input  logic [7:0]  bus_d_in,
    output logic        halt,
    output logic [15:0] addr,
    output logic [7:0]  d_out,
    output logic        we,
    output logic        busy
);
    import nes_pkg::*;

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       parity_q;
    logic       halt_q;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_we && cpu_addr == DMA_REG) begin
                    page_d  = cpu_d_out;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            // An odd cycle costs one extra alignment slot before reads start
            S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                data_d  = bus_d_in;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
            halt_q   <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        addr  = cpu_addr;
        d_out = cpu_d_out;
        we    = cpu_we;
        unique case (state_q)
            S_IDLE: ;
            S_HALT,
            S_ALIGN: we = 1'b0;
            S_READ: begin
                addr = {page_q, idx_q};
                we   = 1'b0;
            end
            S_WRITE: begin
                addr  = OAM_PORT;
                d_out = data_q;
                we    = 1'b1;
            end
            default: we = 1'b0;
        endcase
    end

    assign halt = halt_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: cycle-level reference of the transfer schedule
// plus directed scenarios with literal expectations.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_we;
    logic [7:0]  bus_d_in;
    logic        halt;
    logic [15:0] addr;
    logic [7:0]  d_out;
    logic        we;
    logic        busy;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_d_out (cpu_d_out),
        .cpu_we    (cpu_we),
        .bus_d_in  (bus_d_in),
        .halt      (halt),
        .addr      (addr),
        .d_out     (d_out),
        .we        (we),
        .busy      (busy)
    );

    // Memory contents: page 03 holds byte i at offset i
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] - 8'd3);
    endfunction

    assign bus_d_in = mem(addr);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a transfer is a numbered sequence of cycles k.
    // k=0 stall, k=1 alignment if started odd, then read/write pairs.
    logic       m_busy, m_par, m_align;
    logic [7:0] m_page;
    int         m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_par   <= 1'b0;
            m_align <= 1'b0;
            m_page  <= 8'h00;
            m_k     <= 0;
        end else begin
            m_par <= ~m_par;
            if (!m_busy) begin
                if (cpu_we && cpu_addr == 16'h4014) begin
                    m_busy  <= 1'b1;
                    m_page  <= cpu_d_out;
                    m_k     <= 0;
                    m_align <= ~m_par;
                end
            end else if (m_k == 512 + int'(m_align)) begin
                m_busy <= 1'b0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    int          halt_cnt;
    int          oam_wr;
    logic [15:0] first_rd, last_rd;
    logic [7:0]  wr_q[$];

    always @(negedge clk) begin
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ewe, cd;
        int          j;
        ea = cpu_addr;
        ed = cpu_d_out;
        ewe = cpu_we;
        cd = 1'b1;
        if (m_busy) begin
            ewe = 1'b0;
            cd = 1'b0;
            if (m_k >= 1 + int'(m_align)) begin
                j = m_k - 1 - int'(m_align);
                if (j % 2 == 0) begin
                    ea = {m_page, 8'(j / 2)};
                    if (j == 0) first_rd = addr;
                    last_rd = addr;
                end else begin
                    ea = 16'h2004;
                    ewe = 1'b1;
                    ed = mem({m_page, 8'((j - 1) / 2)});
                    cd = 1'b1;
                    wr_q.push_back(d_out);
                end
            end
        end
        chk("halt", {31'd0, halt}, {31'd0, m_busy});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("addr", {16'd0, addr}, {16'd0, ea});
        chk("we", {31'd0, we}, {31'd0, ewe});
        if (cd) chk("d_out", {24'd0, d_out}, {24'd0, ed});
        if (halt) halt_cnt++;
        if (we && addr == 16'h2004) oam_wr++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic trigger(input logic [7:0] pg, input bit odd);
        if (m_par == odd) step();
        cpu_addr  = 16'h4014;
        cpu_d_out = pg;
        cpu_we    = 1'b1;
        step();
        cpu_we    = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_d_out = 8'h5A;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (busy && c < 1000) begin
            step();
            c++;
        end
        chk("done_timeout", {31'd0, c < 1000}, 32'd1);
        step();
        step();
    endtask

    task automatic clr();
        halt_cnt = 0;
        oam_wr = 0;
        wr_q.delete();
        first_rd = 16'hxxxx;
        last_rd = 16'hxxxx;
    endtask

    initial begin
        int c;
        rst = 1'b1;
        cpu_addr = 16'h0000;
        cpu_d_out = 8'h00;
        cpu_we = 1'b0;
        clr();
        #12;
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_idx", {24'd0, dut.idx_q}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();

        cpu_addr = 16'h0010;
        cpu_d_out = 8'hAA;
        cpu_we = 1'b1;
        #1;
        chk("pt_addr", {16'd0, addr}, 32'h0010);
        chk("pt_dout", {24'd0, d_out}, 32'hAA);
        chk("pt_we", {31'd0, we}, 32'd1);
        chk("pt_busy", {31'd0, busy}, 32'd0);
        step();
        chk("pt_busy2", {31'd0, busy}, 32'd0);
        cpu_we = 1'b0;
        step();

        clr();
        trigger(8'h02, 1'b0);
        repeat (100) step();
        cpu_addr = 16'h4014;
        cpu_d_out = 8'h77;
        cpu_we = 1'b1;
        step();
        cpu_we = 1'b0;
        cpu_addr = 16'h1234;
        wait_done();
        chk("even_halt_len", halt_cnt, 513);
        chk("even_first_rd", {16'd0, first_rd}, 32'h0200);
        chk("even_last_rd", {16'd0, last_rd}, 32'h02FF);
        chk("even_writes", oam_wr, 256);

        clr();
        trigger(8'h02, 1'b1);
        wait_done();
        chk("odd_halt_len", halt_cnt, 514);
        chk("odd_writes", oam_wr, 256);

        clr();
        trigger(8'h03, 1'b0);
        wait_done();
        chk("p3_count", wr_q.size(), 256);
        for (int i = 0; i < 256 && i < wr_q.size(); i++)
            chk("p3_data", {24'd0, wr_q[i]}, i);

        clr();
        trigger(8'h05, 1'b0);
        c = 0;
        while (m_k != 1 + 2 * 8'h40 && c < 1000) begin
            step();
            c++;
        end
        chk("rst_wait_timeout", {31'd0, c < 1000}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_halt", {31'd0, halt}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", {16'd0, addr}, {16'd0, cpu_addr});
        chk("mid_rst_idx", {24'd0, dut.idx_q}, 32'd0);
        step();
        step();
        rst = 1'b0;
        oam_wr = 0;
        repeat (600) step();
        chk("post_rst_writes", oam_wr, 0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        clr();
        trigger(8'hFF, 1'b1);
        wait_done();
        chk("ff_first_rd", {16'd0, first_rd}, 32'hFF00);
        chk("ff_last_rd", {16'd0, last_rd}, 32'hFFFF);
        chk("ff_idx", {24'd0, dut.idx_q}, 32'd0);
        chk("ff_busy", {31'd0, busy}, 32'd0);
        chk("ff_halt_len", halt_cnt, 514);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter: DMA_REG, 16'h4014, CPU write address that triggers a DMA.
REQ-002 Parameter: OAM_PORT, 16'h2004, PPU OAM data port the DMA writes into.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: cpu_addr  in  16  CPU address output.
REQ-006 Port: cpu_d_out  in  8  CPU write data.
REQ-007 Port: cpu_we  in  1  CPU write strobe.
REQ-008 Port: bus_d_in  in  8  read data from the memory map, valid in the same cycle as addr.
REQ-009 Port: halt  out  1  registered stall to the CPU; the CPU SHALL freeze PC, state and registers while high.
REQ-010 Port: addr  out  16  system address bus.
REQ-011 Port: d_out  out  8  system write data.
REQ-012 Port: we  out  1  system write strobe.
REQ-013 Port: busy  out  1  high in every non-IDLE state.

Function
REQ-014 FSM states SHALL be IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 In IDLE, addr/d_out/we SHALL combinationally equal cpu_addr/cpu_d_out/cpu_we, with zero-cycle latency.
REQ-016 IDLE with cpu_we=1 and cpu_addr==DMA_REG in cycle N: page SHALL be latched from cpu_d_out and the FSM SHALL be in HALT at N+1; that CPU write SHALL still pass through in cycle N.
REQ-017 halt SHALL be high in every cycle where state is not IDLE.
REQ-018 parity SHALL be a 1-bit free-running toggle, 0 out of reset.
REQ-019 In HALT, the next state SHALL be ALIGN if parity==1, else READ.
REQ-020 ALIGN SHALL last one cycle and then go to READ.
REQ-021 HALT and ALIGN SHALL drive addr=cpu_addr and we=0.
REQ-022 In READ: addr={page, idx}, we=0; bus_d_in SHALL be latched into the data register at the cycle end; next state is WRITE.
REQ-023 In WRITE: addr=OAM_PORT, d_out=data register, we=1; idx SHALL increment (8-bit wrap).
REQ-024 WRITE SHALL go to READ if idx!=8'hFF before the increment, else to IDLE.
REQ-025 Total halt length SHALL be 513 cycles (even start) or 514 cycles (odd start); exactly 256 writes occur, in order idx 00..FF.
REQ-026 cpu_we/cpu_addr SHALL be ignored while busy; a DMA_REG write during DMA SHALL NOT restart or re-latch page.
REQ-027 Page FF SHALL read FF00..FFFF with no wrap into page 00.
REQ-028 A trigger in the same cycle the FSM returns to IDLE is impossible (the CPU is halted), so no special case is needed.

Reset
REQ-029 rst SHALL force IDLE, halt=0, busy=0, page=0, idx=0, data=0, parity=0 immediately, including mid-transfer.
REQ-030 After reset release, outputs SHALL be in IDLE pass-through and no partial transfer SHALL resume.

Structure
REQ-031 The state enum and the DMA_REG/OAM_PORT address constants SHALL live in the shared package nes_pkg; cpu and the memory map decoder import it.
REQ-032 No sub-module: one FSM, three registers (page, idx, data), a parity flop and an inline output mux.

Verification
REQ-033 Trigger: write 8'h02 to 16'h4014 with parity even. Required: halt high 513 cycles; first READ addr 16'h0200; last WRITE when addr 16'h02FF is read.
REQ-034 Same trigger with parity odd. Required: one ALIGN cycle, then halt high 514 cycles total.
REQ-035 Memory holds byte i at 16'h0300+i; trigger page 03. Required: 256 writes to 16'h2004 with data 00..FF in order, and we high only in WRITE.
REQ-036 Assert rst at idx 8'h40 mid-transfer. Required: halt=0, busy=0 and addr==cpu_addr asynchronously; no further writes to 16'h2004.
REQ-037 Pass-through: CPU writes 8'hAA to 16'h0010 while idle. Required: addr=16'h0010, d_out=8'hAA, we=1 in the same cycle, and busy stays 0.
REQ-038 Page FF transfer. Required: final READ addr 16'hFFFF, then IDLE with idx=0.
